sprite_store_scheduler: RTL and testbench

//  Sequences the 10-slot sprite X store and its matchers for one scanline. During OAM scan it

---
 rtl/sprite_store_scheduler.sv | 175 +++++++++++++++++
 tb/tb_sprite_store_scheduler.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_store_scheduler.sv
// Per-scanline sequencer for the 10-slot sprite X store: allocates slots during OAM scan,
// then serves X matches lowest-slot-first by stalling the pixel pipe and requesting fetches.
module sprite_store_scheduler #(
    parameter int SLOTS  = 10,
    parameter int IDX_W  = 6,
    parameter int LINE_W = 4
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              line_start,
    input  logic              scan_valid,
    input  logic              scan_hit,
    input  logic [IDX_W-1:0]  scan_idx,
    input  logic [LINE_W-1:0] scan_row,
    input  logic              scan_done,
    input  logic [SLOTS-1:0]  match,
    input  logic              fetch_ack,
    output logic [SLOTS-1:0]  store_we,
    output logic [SLOTS-1:0]  slot_reset,
    output logic              fetch_req,
    output logic [IDX_W-1:0]  fetch_idx,
    output logic [LINE_W-1:0] fetch_row,
    output logic              pipe_stall,
    output logic [3:0]        sprite_count,
    output logic              store_full
);

    localparam int         SEL_W   = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [3:0] SLOTS_C = 4'(SLOTS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_RENDER,
        ST_FETCH,
        ST_FREE
    } state_t;

    state_t              state_reg;
    logic [SLOTS-1:0]    valid_reg;
    logic [SLOTS-1:0]    valid_next;
    logic [SLOTS-1:0]    store_we_reg;
    logic [SLOTS-1:0]    slot_reset_reg;
    logic [3:0]          count_reg;
    logic                full_reg;
    logic [SEL_W-1:0]    active_reg;
    logic [IDX_W-1:0]    fetch_idx_reg;
    logic [LINE_W-1:0]   fetch_row_reg;

    logic [IDX_W-1:0]    slot_idx_reg [SLOTS];
    logic [LINE_W-1:0]   slot_row_reg [SLOTS];

    logic [SLOTS-1:0]    qual;
    logic                qual_any;
    logic [SEL_W-1:0]    sel;
    logic                scan_take;
    logic                render_go;
    logic                free_go;
    logic [SLOTS-1:0]    alloc_we;
    logic [SLOTS-1:0]    free_onehot;

    assign qual      = match & valid_reg;
    assign qual_any  = |qual;
    assign scan_take = (state_reg == ST_SCAN) && scan_valid && scan_hit && !full_reg && !line_start;
    assign render_go = (state_reg == ST_RENDER) && qual_any && !line_start;
    assign free_go   = (state_reg == ST_FETCH) && fetch_ack && !line_start;

    // Lowest set bit wins: slot 0 has the highest priority among same-X sprites.
    always_comb begin
        sel = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (qual[i]) begin
                sel = SEL_W'(i);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
            assign alloc_we[gi]    = scan_take && (count_reg == 4'(gi));
            assign free_onehot[gi] = (active_reg == SEL_W'(gi));
            assign valid_next[gi]  = line_start                       ? 1'b0 :
                                     alloc_we[gi]                     ? 1'b1 :
                                     (free_go && free_onehot[gi])     ? 1'b0 :
                                                                        valid_reg[gi];
        end
    endgenerate

    // Slot payload only matters while its valid bit is set, so it carries no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < SLOTS; i++) begin
            if (alloc_we[i]) begin
                slot_idx_reg[i] <= scan_idx;
                slot_row_reg[i] <= scan_row;
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            valid_reg <= '0;
        end else begin
            valid_reg <= valid_next;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_reg      <= ST_IDLE;
            store_we_reg   <= '0;
            slot_reset_reg <= '0;
            count_reg      <= '0;
            full_reg       <= 1'b0;
            active_reg     <= '0;
            fetch_idx_reg  <= '0;
            fetch_row_reg  <= '0;
        end else begin
            store_we_reg   <= '0;
            slot_reset_reg <= '0;
            if (line_start) begin
                // Abandons any fetch in flight; a late fetch_ack then lands in SCAN and is ignored.
                state_reg      <= ST_SCAN;
                count_reg      <= '0;
                full_reg       <= 1'b0;
                slot_reset_reg <= '1;
                fetch_idx_reg  <= '0;
                fetch_row_reg  <= '0;
            end else begin
                case (state_reg)
                    ST_SCAN: begin
                        if (scan_take) begin
                            store_we_reg <= alloc_we;
                            count_reg    <= count_reg + 4'd1;
                            full_reg     <= ((count_reg + 4'd1) == SLOTS_C);
                        end
                        if (scan_done) begin
                            state_reg <= ST_RENDER;
                        end
                    end
                    ST_RENDER: begin
                        if (render_go) begin
                            state_reg     <= ST_FETCH;
                            active_reg    <= sel;
                            fetch_idx_reg <= slot_idx_reg[sel];
                            fetch_row_reg <= slot_row_reg[sel];
                        end
                    end
                    ST_FETCH: begin
                        if (free_go) begin
                            state_reg      <= ST_FREE;
                            slot_reset_reg <= free_onehot;
                        end
                    end
                    ST_FREE: begin
                        state_reg <= ST_RENDER;
                    end
                    default: begin
                        state_reg <= state_reg;
                    end
                endcase
            end
        end
    end

    // The request is raised in the very cycle the match is seen so the pixel pipe stops at once.
    assign fetch_req    = (state_reg == ST_FETCH) || render_go;
    assign pipe_stall   = (state_reg == ST_FETCH) || (state_reg == ST_FREE) || render_go;
    assign fetch_idx    = render_go ? slot_idx_reg[sel] : fetch_idx_reg;
    assign fetch_row    = render_go ? slot_row_reg[sel] : fetch_row_reg;
    assign store_we     = store_we_reg;
    assign slot_reset   = slot_reset_reg;
    assign sprite_count = count_reg;
    assign store_full   = full_reg;

endmodule

// File: tb/tb_sprite_store_scheduler.sv
// Directed bench for sprite_store_scheduler: scoreboard queues hold expected store strobes
// and fetch order, popped when the scheduler responds.
module tb_sprite_store_scheduler;

    localparam int SLOTS  = 10;
    localparam int IDX_W  = 6;
    localparam int LINE_W = 4;

    logic              clk        = 1'b0;
    logic              nreset     = 1'b0;
    logic              line_start = 1'b0;
    logic              scan_valid = 1'b0;
    logic              scan_hit   = 1'b0;
    logic [IDX_W-1:0]  scan_idx   = '0;
    logic [LINE_W-1:0] scan_row   = '0;
    logic              scan_done  = 1'b0;
    logic [SLOTS-1:0]  match      = '0;
    logic              fetch_ack  = 1'b0;
    logic [SLOTS-1:0]  store_we;
    logic [SLOTS-1:0]  slot_reset;
    logic              fetch_req;
    logic [IDX_W-1:0]  fetch_idx;
    logic [LINE_W-1:0] fetch_row;
    logic              pipe_stall;
    logic [3:0]        sprite_count;
    logic              store_full;

    sprite_store_scheduler #(.SLOTS(SLOTS), .IDX_W(IDX_W), .LINE_W(LINE_W)) dut (
        .clk(clk), .nreset(nreset), .line_start(line_start), .scan_valid(scan_valid),
        .scan_hit(scan_hit), .scan_idx(scan_idx), .scan_row(scan_row), .scan_done(scan_done),
        .match(match), .fetch_ack(fetch_ack), .store_we(store_we), .slot_reset(slot_reset),
        .fetch_req(fetch_req), .fetch_idx(fetch_idx), .fetch_row(fetch_row),
        .pipe_stall(pipe_stall), .sprite_count(sprite_count), .store_full(store_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                slot;
        logic [IDX_W-1:0]  idx;
        logic [LINE_W-1:0] row;
    } fetch_t;

    int                n_cmp = 0;
    int                n_err = 0;
    int                model_count = 0;
    bit                in_scan = 1'b0;
    logic [IDX_W-1:0]  m_idx [SLOTS];
    logic [LINE_W-1:0] m_row [SLOTS];
    logic [SLOTS-1:0]  m_valid = '0;
    logic [SLOTS-1:0]  we_q [$];
    fetch_t            fetch_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    function automatic logic [SLOTS-1:0] onehot(input int n);
        logic [SLOTS-1:0] v;
        v = '0;
        v[n] = 1'b1;
        return v;
    endfunction

    task automatic start_line();
        match      = '0;
        line_start = 1'b1;
        tick();
        line_start  = 1'b0;
        in_scan     = 1'b1;
        model_count = 0;
        m_valid     = '0;
        chk("line_slot_reset", 32'(slot_reset), 32'(10'h3FF));
        $display("line_start: slot_reset=%h count=%0d", slot_reset, sprite_count);
    endtask

    task automatic scan_entry(input bit v, input bit h, input int idx, input int row);
        logic [SLOTS-1:0] exp;
        scan_valid = v;
        scan_hit   = h;
        scan_idx   = IDX_W'(idx);
        scan_row   = LINE_W'(row);
        exp = '0;
        if (in_scan && v && h && model_count < SLOTS) begin
            exp = onehot(model_count);
            m_idx[model_count] = IDX_W'(idx);
            m_row[model_count] = LINE_W'(row);
            m_valid[model_count] = 1'b1;
            model_count++;
        end
        we_q.push_back(exp);
        tick();
        scan_valid = 1'b0;
        scan_hit   = 1'b0;
        chk("store_we", 32'(store_we), 32'(we_q.pop_front()));
        $display("scan idx=%0d hit=%0b: store_we=%h count=%0d", idx, v && h, store_we, sprite_count);
    endtask

    task automatic finish_scan();
        scan_done = 1'b1;
        tick();
        scan_done = 1'b0;
        in_scan   = 1'b0;
    endtask

    // Drive a match vector in RENDER and serve every qualifying slot, lowest first.
    task automatic serve(input logic [SLOTS-1:0] match_v);
        fetch_t e;
        int     n;
        match = match_v;
        for (int s = 0; s < SLOTS; s++) begin
            if (match_v[s] && m_valid[s]) begin
                fetch_q.push_back('{slot: s, idx: m_idx[s], row: m_row[s]});
            end
        end
        while (fetch_q.size() > 0) begin
            e = fetch_q.pop_front();
            settle();
            n = 0;
            while (!fetch_req && n < 8) begin
                tick();
                settle();
                n++;
            end
            chk("fetch_req_rise", 32'(fetch_req), 32'(1));
            chk("fetch_idx", 32'(fetch_idx), 32'(e.idx));
            chk("fetch_row", 32'(fetch_row), 32'(e.row));
            chk("stall_render", 32'(pipe_stall), 32'(1));
            tick();
            match = ~match_v;
            settle();
            chk("fetch_hold_req", 32'(fetch_req), 32'(1));
            chk("fetch_hold_idx", 32'(fetch_idx), 32'(e.idx));
            chk("stall_fetch", 32'(pipe_stall), 32'(1));
            fetch_ack = 1'b1;
            tick();
            fetch_ack = 1'b0;
            match     = match_v;
            settle();
            chk("free_slot_reset", 32'(slot_reset), 32'(onehot(e.slot)));
            chk("free_fetch_req", 32'(fetch_req), 32'(0));
            chk("stall_free", 32'(pipe_stall), 32'(1));
            m_valid[e.slot] = 1'b0;
            $display("fetch slot=%0d idx=%0d row=%0d freed slot_reset=%h", e.slot, e.idx, e.row, slot_reset);
            tick();
        end
        settle();
        chk("idle_stall", 32'(pipe_stall), 32'(0));
        chk("idle_fetch_req", 32'(fetch_req), 32'(0));
        chk("idle_slot_reset", 32'(slot_reset), 32'(0));
        tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_store_we"}, 32'(store_we), 32'(0));
        chk({tag, "_slot_reset"}, 32'(slot_reset), 32'(0));
        chk({tag, "_fetch_req"}, 32'(fetch_req), 32'(0));
        chk({tag, "_fetch_idx"}, 32'(fetch_idx), 32'(0));
        chk({tag, "_fetch_row"}, 32'(fetch_row), 32'(0));
        chk({tag, "_pipe_stall"}, 32'(pipe_stall), 32'(0));
        chk({tag, "_count"}, 32'(sprite_count), 32'(0));
        chk({tag, "_full"}, 32'(store_full), 32'(0));
        $display("%s: outputs checked against zero", tag);
    endtask

    initial begin
        // Reset state, then hits while IDLE must not allocate.
        repeat (2) tick();
        chk_all_zero("reset");
        nreset = 1'b1;
        tick();
        scan_entry(1'b1, 1'b1, 3, 3);
        chk("idle_count", 32'(sprite_count), 32'(0));

        // Twelve hits: strobe walks slots 0..9, the last two are dropped.
        start_line();
        for (int k = 0; k < 12; k++) begin
            scan_entry(1'b1, 1'b1, k, k % 16);
        end
        chk("full_count", 32'(sprite_count), 32'(SLOTS));
        chk("full_flag", 32'(store_full), 32'(1));
        finish_scan();
        serve(10'h3FF);

        // Three hits with a miss between, single fetch, then freed slot re-presented.
        start_line();
        scan_entry(1'b1, 1'b1, 5, 1);
        scan_entry(1'b1, 1'b0, 30, 9);
        scan_entry(1'b1, 1'b1, 9, 2);
        scan_entry(1'b1, 1'b1, 20, 3);
        chk("three_count", 32'(sprite_count), 32'(3));
        chk("three_full", 32'(store_full), 32'(0));
        finish_scan();
        serve(10'b0000000010);
        serve(10'b0000000010);

        // Same-X tie over slots 0..2.
        start_line();
        scan_entry(1'b1, 1'b1, 7, 4);
        scan_entry(1'b1, 1'b1, 8, 5);
        scan_entry(1'b1, 1'b1, 9, 6);
        finish_scan();
        serve(10'b0000000111);

        // line_start during FETCH abandons it; a late ack does nothing.
        start_line();
        scan_entry(1'b1, 1'b1, 33, 7);
        finish_scan();
        match = 10'b0000000001;
        settle();
        chk("abandon_req_pre", 32'(fetch_req), 32'(1));
        tick();
        start_line();
        settle();
        chk("abandon_req", 32'(fetch_req), 32'(0));
        chk("abandon_stall", 32'(pipe_stall), 32'(0));
        chk("abandon_count", 32'(sprite_count), 32'(0));
        fetch_ack = 1'b1;
        tick();
        fetch_ack = 1'b0;
        settle();
        chk("late_ack_slot_reset", 32'(slot_reset), 32'(0));
        chk("late_ack_stall", 32'(pipe_stall), 32'(0));
        finish_scan();
        match = '1;
        settle();
        chk("empty_render_stall", 32'(pipe_stall), 32'(0));
        tick();
        settle();
        chk("empty_render_req", 32'(fetch_req), 32'(0));
        $display("abandoned fetch: late ack ignored, empty render stall=%0b", pipe_stall);

        // Asynchronous reset mid-FETCH.
        start_line();
        scan_entry(1'b1, 1'b1, 12, 3);
        finish_scan();
        match = 10'b0000000001;
        tick();
        settle();
        chk("prereset_req", 32'(fetch_req), 32'(1));
        nreset = 1'b0;
        #1;
        chk_all_zero("async_reset");
        in_scan     = 1'b0;
        model_count = 0;
        m_valid     = '0;
        match       = '0;
        tick();
        nreset = 1'b1;
        tick();
        scan_entry(1'b1, 1'b1, 4, 4);
        chk("post_reset_count", 32'(sprite_count), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
